// File: rtl/hist_eq_pkg.sv
// Shared definitions for the histogram-equalisation scan controller.
// Also used by the optional clip path selected with HIST_CLIP_EN.
package hist_eq_pkg;

    localparam int unsigned DEF_HIST_RAM_AW = 13;
    localparam int unsigned DEF_HIST_RAM_DW = 19;
    localparam int unsigned DEF_OUT_DW      = 12;
    localparam int unsigned DEF_DW          = 13;

    // Cycles spent draining the read/clear/output pipeline after the last read
    localparam int unsigned FLUSH_CYC = 2;

    // Scan sequencer states
    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StWaitStat = 3'd1;
    localparam logic [2:0] StScanDn   = 3'd2;
    localparam logic [2:0] StScanUp   = 3'd3;
    localparam logic [2:0] StFlush    = 3'd4;
    localparam logic [2:0] StDone     = 3'd5;

endpackage

// File: rtl/hist_eq_scan_ctrl_if.sv
// Histogram RAM access bundle: read port plus the clear-behind write port.
// master = scan controller, slave = RAM wrapper.
interface hist_eq_scan_ctrl_if
    import hist_eq_pkg::*;
#(
    parameter int unsigned AW = DEF_HIST_RAM_AW,
    parameter int unsigned DW = DEF_HIST_RAM_DW
);
    logic [AW-1:0] hist_rd_addr;
    logic          hist_rd_en;
    logic [DW-1:0] hist_rd_q;
    logic          hist_wr_en;
    logic [AW-1:0] hist_wr_addr;

    modport master (
        output hist_rd_addr, hist_rd_en, hist_wr_en, hist_wr_addr,
        input  hist_rd_q
    );

    modport slave (
        input  hist_rd_addr, hist_rd_en, hist_wr_en, hist_wr_addr,
        output hist_rd_q
    );
endinterface

// File: rtl/hist_eq_sat.sv
// Registered clip/saturate stage: out = min(q, limit), limit <= 2^OUT_DW-1.
// Passing limit = all-ones gives plain saturation.
module hist_eq_sat
    import hist_eq_pkg::*;
#(
    parameter int unsigned IN_DW  = DEF_HIST_RAM_DW,
    parameter int unsigned OUT_DW = DEF_OUT_DW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    input  logic [IN_DW-1:0]  q,
    input  logic [OUT_DW-1:0] limit,
    output logic              out_vld,
    output logic [OUT_DW-1:0] out_data
);
    logic [OUT_DW-1:0] data_d;

    // Limit the raw count; result always fits OUT_DW
    always_comb begin
        data_d = limit;
        if (q <= IN_DW'(limit)) data_d = OUT_DW'(q);
    end

    // Output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_data <= '0;
        end else begin
            out_vld  <= in_vld;
            out_data <= data_d;
        end
    end
endmodule

// File: rtl/hist_eq_scan_ctrl.sv
// Frame-level histogram scan: reads bins (mean-1 .. 0, then mean .. top), clears
// each bin behind the read and streams saturated counts to the mapping stage.
// Optional macro HIST_CLIP_EN: clip counts to i_clip_limit latched with the mean.
module hist_eq_scan_ctrl
    import hist_eq_pkg::*;
#(
    parameter int unsigned HIST_RAM_AW = DEF_HIST_RAM_AW,
    parameter int unsigned HIST_RAM_DW = DEF_HIST_RAM_DW,
    parameter int unsigned OUT_DW      = DEF_OUT_DW,
    parameter int unsigned DW          = DEF_DW
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_field_vld,
    input  logic                      i_stat_vld,
    input  logic [DW-1:0]             i_data_aver,
    input  logic [OUT_DW-1:0]         i_clip_limit,
    hist_eq_scan_ctrl_if.master       ram,
    output logic                      o_hist_rd_vld,
    output logic [OUT_DW-1:0]         o_hist_rd_data,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_overrun
);
    localparam int unsigned            MaxBin    = 2 ** HIST_RAM_AW - 1;
    localparam logic [HIST_RAM_AW-1:0] TopAddr   = '1;
    localparam logic [1:0]             FlushLast = 2'(FLUSH_CYC - 1);

    logic [2:0]             state_q, state_d;
    logic [HIST_RAM_AW-1:0] addr_q, addr_d;
    logic [HIST_RAM_AW-1:0] mean_q, mean_d, mean_in;
    logic [HIST_RAM_AW-1:0] wr_addr_q;
    logic [1:0]             flush_cnt_q, flush_cnt_d;
    logic                   field_q, wr_en_q, abort_q, abort_d;
    logic                   field_rise, field_fall, scanning, abort_now;
    logic                   sat_vld;
    logic [OUT_DW-1:0]      limit;

    assign field_rise = i_field_vld & ~field_q;
    assign field_fall = ~i_field_vld & field_q;
    assign scanning   = (state_q == StScanDn) || (state_q == StScanUp);
    assign abort_now  = field_rise && (scanning || (state_q == StWaitStat));
    assign mean_in    = (32'(i_data_aver) > MaxBin) ? TopAddr : HIST_RAM_AW'(i_data_aver);

    // Next-state logic for the scan sequencer
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        mean_d      = mean_q;
        flush_cnt_d = flush_cnt_q;
        abort_d     = abort_q;
        if (abort_now) begin
            // Reads already issued still complete; their outputs are suppressed
            state_d     = StFlush;
            abort_d     = 1'b1;
            flush_cnt_d = '0;
        end else begin
            case (state_q)
                StIdle: if (field_fall) state_d = StWaitStat;
                StWaitStat: begin
                    if (i_stat_vld) begin
                        mean_d = mean_in;
                        if (mean_in != '0) begin
                            state_d = StScanDn;
                            addr_d  = mean_in - 1'b1;
                        end else begin
                            state_d = StScanUp;
                            addr_d  = '0;
                        end
                    end
                end
                StScanDn: begin
                    if (addr_q == '0) begin
                        state_d = StScanUp;
                        addr_d  = mean_q;
                    end else begin
                        addr_d = addr_q - 1'b1;
                    end
                end
                StScanUp: begin
                    if (addr_q == TopAddr) begin
                        state_d     = StFlush;
                        flush_cnt_d = '0;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
                StFlush: begin
                    if (flush_cnt_q == FlushLast) begin
                        state_d = abort_q ? StIdle : StDone;
                        abort_d = 1'b0;
                    end else begin
                        flush_cnt_d = flush_cnt_q + 1'b1;
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Sequencer state, edge detector and clear-behind write pipeline
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            mean_q      <= '0;
            flush_cnt_q <= '0;
            abort_q     <= 1'b0;
            field_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            mean_q      <= mean_d;
            flush_cnt_q <= flush_cnt_d;
            abort_q     <= abort_d;
            field_q     <= i_field_vld;
            wr_en_q     <= ram.hist_rd_en;
            wr_addr_q   <= addr_q;
        end
    end

`ifdef HIST_CLIP_EN
    logic [OUT_DW-1:0] clip_q;

    // Plateau limit is frozen for the whole scan
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clip_q <= '0;
        end else if ((state_q == StWaitStat) && i_stat_vld && !abort_now) begin
            clip_q <= i_clip_limit;
        end
    end

    assign limit = clip_q;
`else
    logic unused_clip;
    assign unused_clip = ^i_clip_limit;
    assign limit       = '1;
`endif

    // q for the read issued last cycle is on the bus now; clear is wr_en_q
    hist_eq_sat #(
        .IN_DW  (HIST_RAM_DW),
        .OUT_DW (OUT_DW)
    ) u_sat (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .in_vld   (wr_en_q),
        .q        (ram.hist_rd_q),
        .limit    (limit),
        .out_vld  (sat_vld),
        .out_data (o_hist_rd_data)
    );

    assign ram.hist_rd_addr = addr_q;
    assign ram.hist_rd_en   = scanning & ~abort_now;
    assign ram.hist_wr_en   = wr_en_q;
    assign ram.hist_wr_addr = wr_addr_q;

    assign o_hist_rd_vld = sat_vld & ~(abort_q | abort_now);
    assign o_busy        = (state_q == StWaitStat) || scanning || (state_q == StFlush);
    assign o_done        = (state_q == StDone);
    assign o_overrun     = abort_now;
endmodule

// File: tb/tb_hist_eq_scan_ctrl.sv
// Directed bench for hist_eq_scan_ctrl with a 16-bin RAM model (AW=4, OUT_DW=4).
module tb_hist_eq_scan_ctrl;
    localparam int unsigned AW    = 4;
    localparam int unsigned RDW   = 19;
    localparam int unsigned ODW   = 4;
    localparam int unsigned MDW   = 13;
    localparam int unsigned NBINS = 16;

`ifdef HIST_CLIP_EN
    localparam logic [ODW-1:0] ExpBin3 = 4'd6;
    localparam logic [ODW-1:0] ExpBin7 = 4'd6;
`else
    localparam logic [ODW-1:0] ExpBin3 = 4'd15;
    localparam logic [ODW-1:0] ExpBin7 = 4'd9;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           field_vld = 1'b0;
    logic           stat_vld = 1'b0;
    logic [MDW-1:0] data_aver = '0;
    logic [ODW-1:0] clip_limit = '1;
    logic           rd_vld, busy, done, overrun;
    logic [ODW-1:0] rd_data;

    int tests = 0;
    int fails = 0;

    hist_eq_scan_ctrl_if #(.AW(AW), .DW(RDW)) ram ();

    hist_eq_scan_ctrl #(
        .HIST_RAM_AW (AW),
        .HIST_RAM_DW (RDW),
        .OUT_DW      (ODW),
        .DW          (MDW)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_field_vld    (field_vld),
        .i_stat_vld     (stat_vld),
        .i_data_aver    (data_aver),
        .i_clip_limit   (clip_limit),
        .ram            (ram),
        .o_hist_rd_vld  (rd_vld),
        .o_hist_rd_data (rd_data),
        .o_busy         (busy),
        .o_done         (done),
        .o_overrun      (overrun)
    );

    always #5 clk = ~clk;

    // RAM model: controls sampled mid-cycle, acted on at the next rising edge
    logic [RDW-1:0] mem [NBINS];
    logic [RDW-1:0] q = '0;
    logic           s_rd_en = 1'b0, s_wr_en = 1'b0;
    logic [AW-1:0]  s_rd_addr = '0, s_wr_addr = '0;
    assign ram.hist_rd_q = q;

    always @(posedge clk) begin
        if (s_rd_en) q <= mem[s_rd_addr];
        if (s_wr_en) mem[s_wr_addr] = '0;
    end

    // Monitor
    logic [AW-1:0]  addr_log [$];
    logic [ODW-1:0] data_log [$];
    int cyc = 0, wr_cnt = 0, ovr_cnt = 0, done_cnt = 0;
    int first_vld = -1, last_vld = -1, done_cyc = -1;

    always @(negedge clk) begin
        cyc++;
        s_rd_en   = ram.hist_rd_en;
        s_rd_addr = ram.hist_rd_addr;
        s_wr_en   = ram.hist_wr_en;
        s_wr_addr = ram.hist_wr_addr;
        if (ram.hist_rd_en) addr_log.push_back(ram.hist_rd_addr);
        if (rd_vld) begin
            if (data_log.size() == 0) first_vld = cyc;
            last_vld = cyc;
            data_log.push_back(rd_data);
        end
        if (ram.hist_wr_en) wr_cnt++;
        if (overrun) ovr_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    function automatic int exp_addr(input int m, input int i);
        return (i < m) ? (m - 1 - i) : i;
    endfunction

    task automatic clear_logs();
        addr_log.delete();
        data_log.delete();
        wr_cnt = 0; ovr_cnt = 0; done_cnt = 0;
        first_vld = -1; last_vld = -1; done_cyc = -1;
    endtask

    task automatic preload_ramp();
        for (int i = 0; i < NBINS; i++) mem[i] = RDW'(i);
    endtask

    // Frame high then low; returns one cycle into WAIT_STAT
    task automatic end_frame();
        @(posedge clk); #1 field_vld = 1'b1;
        repeat (3) @(posedge clk);
        #1 field_vld = 1'b0;
        @(posedge clk); #1;
    endtask

    // Returns during the first scan cycle
    task automatic pulse_stat(input int mean);
        stat_vld  = 1'b1;
        data_aver = MDW'(mean);
        @(posedge clk); #1 stat_vld = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_timeout: busy=%0b required 0", name, busy);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({busy, done, overrun, rd_vld, rd_data} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %b required 0", {busy, done, overrun, rd_vld, rd_data});
        end
        tests++;
        if ({ram.hist_rd_en, ram.hist_wr_en, ram.hist_rd_addr, ram.hist_wr_addr} !== '0) begin
            fails++;
            $display("FAIL reset_ram_if: got %b required 0",
                     {ram.hist_rd_en, ram.hist_wr_en, ram.hist_rd_addr, ram.hist_wr_addr});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_desc_scan();
        int nz = 0;
        preload_ramp();
        clear_logs();
        end_frame();
        pulse_stat(5);
        wait_idle("desc");
        tests++;
        if (addr_log.size() != 16) begin
            fails++; $display("FAIL desc_nreads: got %0d required 16", addr_log.size());
        end
        for (int i = 0; i < addr_log.size(); i++) begin
            tests++;
            if (addr_log[i] !== AW'(exp_addr(5, i))) begin
                fails++;
                $display("FAIL desc_addr[%0d]: got %0d required %0d", i, addr_log[i], exp_addr(5, i));
            end
        end
        tests++;
        if (data_log.size() != 16) begin
            fails++; $display("FAIL desc_nvld: got %0d required 16", data_log.size());
        end
        for (int i = 0; i < data_log.size(); i++) begin
            tests++;
            if (data_log[i] !== ODW'(exp_addr(5, i))) begin
                fails++;
                $display("FAIL desc_data[%0d]: got %0d required %0d", i, data_log[i], exp_addr(5, i));
            end
        end
        tests++;
        if (last_vld - first_vld + 1 != 16) begin
            fails++; $display("FAIL desc_vld_span: got %0d required 16", last_vld - first_vld + 1);
        end
        tests++;
        if (done_cnt != 1 || done_cyc != last_vld + 1) begin
            fails++;
            $display("FAIL desc_done: count %0d at cyc %0d required 1 at cyc %0d",
                     done_cnt, done_cyc, last_vld + 1);
        end
        for (int i = 0; i < NBINS; i++) if (mem[i] != '0) nz++;
        tests++;
        if (nz != 0) begin
            fails++; $display("FAIL desc_cleared: got %0d nonzero bins required 0", nz);
        end
    endtask

    task automatic test_mean_edges();
        int mean_in [2] = '{0, 20};
        int mean_cl [2] = '{0, 15};
        for (int t = 0; t < 2; t++) begin
            preload_ramp();
            clear_logs();
            end_frame();
            pulse_stat(mean_in[t]);
            wait_idle("mean_edge");
            tests++;
            if (addr_log.size() != 16 || done_cnt != 1) begin
                fails++;
                $display("FAIL mean%0d_count: reads %0d done %0d required 16 and 1",
                         mean_in[t], addr_log.size(), done_cnt);
            end
            for (int i = 0; i < addr_log.size(); i++) begin
                tests++;
                if (addr_log[i] !== AW'(exp_addr(mean_cl[t], i))) begin
                    fails++;
                    $display("FAIL mean%0d_addr[%0d]: got %0d required %0d", mean_in[t], i,
                             addr_log[i], exp_addr(mean_cl[t], i));
                end
            end
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < NBINS; i++) mem[i] = '0;
        mem[3] = RDW'(100);
        mem[7] = RDW'(9);
        clip_limit = 4'd6;
        clear_logs();
        end_frame();
        pulse_stat(5);
        wait_idle("sat");
        clip_limit = '1;
        tests++;
        if (data_log.size() != 16) begin
            fails++; $display("FAIL sat_nvld: got %0d required 16", data_log.size());
        end else begin
            tests++;
            if (data_log[1] !== ExpBin3) begin
                fails++; $display("FAIL sat_bin3: got %0d required %0d", data_log[1], ExpBin3);
            end
            tests++;
            if (data_log[7] !== ExpBin7) begin
                fails++; $display("FAIL sat_bin7: got %0d required %0d", data_log[7], ExpBin7);
            end
            tests++;
            if (data_log[0] !== 4'd0) begin
                fails++; $display("FAIL sat_bin4: got %0d required 0", data_log[0]);
            end
        end
    endtask

    task automatic test_abort();
        logic [ODW-1:0] exp_d [4] = '{4'd4, 4'd3, 4'd2, 4'd1};
        preload_ramp();
        clear_logs();
        end_frame();
        pulse_stat(5);
        repeat (6) @(posedge clk);
        #1 field_vld = 1'b1;
        wait_idle("abort");
        tests++;
        if (ovr_cnt != 1 || done_cnt != 0) begin
            fails++;
            $display("FAIL abort_pulses: overrun %0d done %0d required 1 and 0", ovr_cnt, done_cnt);
        end
        tests++;
        if (addr_log.size() != 6 || wr_cnt != 6) begin
            fails++;
            $display("FAIL abort_ops: reads %0d clears %0d required 6 and 6", addr_log.size(), wr_cnt);
        end
        tests++;
        if (data_log.size() != 4) begin
            fails++; $display("FAIL abort_nvld: got %0d required 4", data_log.size());
        end
        for (int i = 0; i < data_log.size() && i < 4; i++) begin
            tests++;
            if (data_log[i] !== exp_d[i]) begin
                fails++; $display("FAIL abort_data[%0d]: got %0d required %0d", i, data_log[i], exp_d[i]);
            end
        end
        tests++;
        if (mem[5] !== '0 || mem[6] !== RDW'(6) || mem[0] !== '0) begin
            fails++;
            $display("FAIL abort_bins: bin5 %0d bin6 %0d bin0 %0d required 0 6 0", mem[5], mem[6], mem[0]);
        end
        tests++;
        if (busy !== 1'b0 || dut.state_q !== 3'd0) begin
            fails++; $display("FAIL abort_idle: busy %0b state %0d required 0 0", busy, dut.state_q);
        end
    endtask

    task automatic test_double_stat();
        int bad = 0;
        preload_ramp();
        clear_logs();
        end_frame();
        stat_vld  = 1'b1;
        data_aver = MDW'(5);
        @(posedge clk); #1 data_aver = MDW'(9);
        @(posedge clk); #1 stat_vld = 1'b0;
        wait_idle("dstat");
        tests++;
        if (addr_log.size() != 16 || addr_log[0] !== 4'd4) begin
            fails++;
            $display("FAIL dstat_start: reads %0d first %0d required 16 and 4",
                     addr_log.size(), addr_log.size() ? addr_log[0] : 4'd0);
        end
        for (int i = 0; i < addr_log.size(); i++) if (addr_log[i] !== AW'(exp_addr(5, i))) bad++;
        tests++;
        if (bad != 0 || done_cnt != 1) begin
            fails++;
            $display("FAIL dstat_seq: %0d bad addrs done %0d required 0 and 1", bad, done_cnt);
        end
    endtask

    task automatic test_reset_mid_scan();
        preload_ramp();
        clear_logs();
        end_frame();
        pulse_stat(5);
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if ({busy, done, overrun, rd_vld, rd_data, ram.hist_rd_en, ram.hist_wr_en,
             ram.hist_rd_addr, ram.hist_wr_addr} !== '0) begin
            fails++;
            $display("FAIL midrst_outputs: got %b required 0",
                     {busy, done, overrun, rd_vld, rd_data, ram.hist_rd_en, ram.hist_wr_en,
                      ram.hist_rd_addr, ram.hist_wr_addr});
        end
        @(posedge clk); #1 rst_n = 1'b1;
        preload_ramp();
        clear_logs();
        end_frame();
        pulse_stat(0);
        wait_idle("midrst");
        tests++;
        if (addr_log.size() != 16 || data_log.size() != 16 || done_cnt != 1) begin
            fails++;
            $display("FAIL midrst_rescan: reads %0d vld %0d done %0d required 16 16 1",
                     addr_log.size(), data_log.size(), done_cnt);
        end
        for (int i = 0; i < data_log.size(); i++) begin
            tests++;
            if (data_log[i] !== ODW'(i)) begin
                fails++; $display("FAIL midrst_data[%0d]: got %0d required %0d", i, data_log[i], i);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NBINS; i++) mem[i] = '0;
        test_reset();
        test_desc_scan();
        test_mean_edges();
        test_saturate();
        test_abort();
        test_double_stat();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
